// File: rtl/updown_sweep_ctrl_if.sv
// Control/status bus between the register block and the sweep controller.
// The master drives run requests; the slave (the controller) reports status.
interface updown_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic       mode;
    logic [3:0] limit;
    logic       busy;
    logic       done;
    logic       err;
    logic       peak;
    logic [7:0] sweeps;

    modport master (
        output start, abort, mode, limit,
        input  busy, done, err, peak, sweeps
    );

    modport slave (
        input  start, abort, mode, limit,
        output busy, done, err, peak, sweeps
    );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Drives Reset/Down of a free-running 4-bit up/down counter so it sweeps
// 0 -> limit -> 0, once or continuously, with busy/done/peak/err status.
module updown_sweep_ctrl (
    input  logic                       clock,
    input  logic                       Reset,
    updown_sweep_ctrl_if.slave         ctl,
    input  logic [3:0]                 cnt_q,
    output logic                       cnt_reset,
    output logic                       cnt_down
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] lim_r;
    logic       mode_r;
    logic [7:0] sweeps_r;
    logic       done_r;
    logic       err_r;
    logic       peak_r;

    logic       done_nxt;
    logic       err_nxt;
    logic       peak_nxt;
    logic       accept;
    logic       sweep_end;

    // Next state and counter control; abort outranks every other input.
    always_comb begin
        state_nxt = state;
        cnt_reset = 1'b0;
        cnt_down  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        peak_nxt  = 1'b0;
        accept    = 1'b0;
        sweep_end = 1'b0;

        case (state)
            IDLE: begin
                cnt_reset = 1'b1;
                if (ctl.start) begin
                    if (ctl.limit != 4'd0) begin
                        accept    = 1'b1;
                        state_nxt = UP;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            UP: begin
                if (ctl.abort) begin
                    cnt_reset = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt_q >= lim_r) begin
                    cnt_down  = 1'b1;
                    peak_nxt  = 1'b1;
                    state_nxt = DOWN;
                end
            end

            DOWN: begin
                if (ctl.abort) begin
                    cnt_reset = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_down = 1'b1;
                end else begin
                    sweep_end = 1'b1;
                    if (!mode_r) begin
                        // Hold at 0 instead of letting the counter wrap to 0xF.
                        cnt_reset = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = UP;
                    end
                end
            end

            default: begin
                cnt_reset = 1'b1;
                state_nxt = IDLE;
            end
        endcase

        if (Reset) begin
            cnt_reset = 1'b1;
            cnt_down  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state    <= IDLE;
            lim_r    <= '0;
            mode_r   <= 1'b0;
            sweeps_r <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            peak_r   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= done_nxt;
            err_r  <= err_nxt;
            peak_r <= peak_nxt;
            if (accept) begin
                lim_r    <= ctl.limit;
                mode_r   <= ctl.mode;
                sweeps_r <= '0;
            end else if (sweep_end && (sweeps_r != 8'hFF)) begin
                sweeps_r <= sweeps_r + 8'd1;
            end
        end
    end

    assign ctl.busy   = (state != IDLE);
    assign ctl.done   = done_r;
    assign ctl.err    = err_r;
    assign ctl.peak   = peak_r;
    assign ctl.sweeps = sweeps_r;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench: a triangle-wave reference model predicts counter values
// and status pulses per run; a negedge monitor checks them against the DUT.
module tb_updown_sweep_ctrl;

    logic       clock = 1'b0;
    logic       Reset;
    logic [3:0] cnt_q;
    logic       cnt_reset;
    logic       cnt_down;

    updown_sweep_ctrl_if ctl ();

    updown_sweep_ctrl dut (
        .clock     (clock),
        .Reset     (Reset),
        .ctl       (ctl),
        .cnt_q     (cnt_q),
        .cnt_reset (cnt_reset),
        .cnt_down  (cnt_down)
    );

    always #5 clock = ~clock;

    // Behavioural 4-bit up/down counter with no enable.
    always_ff @(posedge clock) begin
        if (cnt_reset)     cnt_q <= '0;
        else if (cnt_down) cnt_q <= cnt_q - 4'd1;
        else               cnt_q <= cnt_q + 4'd1;
    end

    typedef struct {
        int kind;   // {done, err, peak}
        int idx;    // cycle index relative to the start edge
        int sw;     // sweeps value visible with the pulse
    } ev_t;

    int  qexp[$];
    ev_t evq[$];
    int  errors = 0;
    int  checks = 0;
    int  model_sweeps = 0;
    bit  mon_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int sat(int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Monitor: counter value on every busy cycle, quiet counter when idle,
    // and every status pulse against the expected event stream.
    initial begin
        int  bc;
        bit  arm;
        ev_t e;
        bc  = 0;
        arm = 1'b0;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (arm) bc = 0;
                else     bc++;
                arm = ctl.start && !ctl.busy;
                if (ctl.busy) begin
                    if (qexp.size() == 0) chk("unexpected_busy", 1, 0);
                    else                  chk("cnt_q", 32'(cnt_q), qexp.pop_front());
                end else begin
                    chk("idle_cnt_q", 32'(cnt_q), 0);
                    chk("idle_cnt_reset", 32'(cnt_reset), 1);
                end
                if ({ctl.done, ctl.err, ctl.peak} != 3'b000) begin
                    if (evq.size() == 0) begin
                        chk("unexpected_pulse", 32'({ctl.done, ctl.err, ctl.peak}), 0);
                    end else begin
                        e = evq.pop_front();
                        chk("pulse_kind", 32'({ctl.done, ctl.err, ctl.peak}), e.kind);
                        chk("pulse_cycle", bc, e.idx);
                        chk("pulse_sweeps", 32'(ctl.sweeps), e.sw);
                    end
                end
            end
        end
    end

    // One run: build expectations from the triangle wave, then drive it.
    // stop_at < 0 means run to completion (single mode only).
    task automatic run(input int lim, input bit md, input int stop_at,
                       input bit by_reset, input bit interfere);
        int  last, ends, c, p;
        bit  stopped;
        if (lim == 0) begin
            evq.push_back('{kind: 2, idx: 0, sw: model_sweeps});
            @(posedge clock); #1;
            ctl.limit = 4'd0; ctl.mode = md; ctl.start = 1'b1;
            @(posedge clock); #1;
            ctl.start = 1'b0;
            repeat (2) @(posedge clock);
            #1;
            chk("err_busy", 32'(ctl.busy), 0);
            return;
        end

        stopped = (stop_at >= 0);
        if (md && !stopped) begin
            stop_at = 4 * lim;
            stopped = 1'b1;
        end
        if (!md && (!stopped || stop_at > 2 * lim)) begin
            stopped = 1'b0;
            last    = 2 * lim;
        end else begin
            last = stop_at;
        end
        if (interfere && stopped && last < 3) interfere = 1'b0;

        ends = 0;
        for (int k = 0; k <= last; k++) begin
            p = k % (2 * lim);
            qexp.push_back((p <= lim) ? p : 2 * lim - p);
            if (stopped && k == last) break;
            if (p == lim) evq.push_back('{kind: 1, idx: k + 1, sw: sat(ends)});
            if (k > 0 && p == 0) begin
                ends++;
                if (!md) evq.push_back('{kind: 4, idx: k + 1, sw: sat(ends)});
            end
        end
        model_sweeps = by_reset ? 0 : sat(ends);

        @(posedge clock); #1;
        ctl.limit = 4'(lim); ctl.mode = md; ctl.start = 1'b1;
        @(posedge clock); #1;
        ctl.start = 1'b0;
        ctl.limit = 4'($urandom);
        ctl.mode  = 1'($urandom);
        c = 0;
        if (interfere) begin
            repeat (2) @(posedge clock);
            #1;
            ctl.start = 1'b1; ctl.limit = 4'd9; ctl.mode = ~md;
            @(posedge clock); #1;
            ctl.start = 1'b0;
            c = 3;
        end
        if (stopped) begin
            while (c < last) begin
                @(posedge clock); #1;
                c++;
            end
            if (by_reset) Reset = 1'b1;
            else          ctl.abort = 1'b1;
            @(posedge clock); #1;
            Reset = 1'b0; ctl.abort = 1'b0;
        end else begin
            while (ctl.busy && c < 100) begin
                @(posedge clock); #1;
                c++;
            end
        end
        chk("busy_end", 32'(ctl.busy), 0);
        @(posedge clock); #1;
        chk("sweeps_end", 32'(ctl.sweeps), model_sweeps);
        chk("cnt_q_drained", qexp.size(), 0);
        // Aborts while idle must leave everything untouched.
        ctl.abort = 1'($urandom);
        @(posedge clock); #1;
        ctl.abort = 1'b0;
    endtask

    initial begin
        int lim, stop;
        bit md, rst, intf;
        Reset = 1'b1;
        ctl.start = 1'b0; ctl.abort = 1'b0; ctl.mode = 1'b0; ctl.limit = 4'd0;
        @(posedge clock); #1;
        mon_en = 1'b1;
        @(posedge clock); #1;
        Reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("reset_busy", 32'(ctl.busy), 0);
        chk("reset_sweeps", 32'(ctl.sweeps), 0);

        run(3, 1'b0, -1, 1'b0, 1'b0);
        run(2, 1'b1, 9, 1'b0, 1'b0);
        run(0, 1'b0, -1, 1'b0, 1'b0);
        run(15, 1'b0, -1, 1'b0, 1'b0);
        run(4, 1'b0, -1, 1'b0, 1'b1);
        run(4, 1'b0, 5, 1'b1, 1'b0);
        run(1, 1'b1, 605, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            lim  = $urandom_range(0, 15);
            md   = 1'($urandom);
            rst  = ($urandom_range(0, 4) == 0);
            intf = ($urandom_range(0, 2) == 0) && (lim >= 2);
            if (md)                            stop = $urandom_range(0, 4 * lim + 3);
            else if ($urandom_range(0, 2) == 0) stop = $urandom_range(0, 2 * lim);
            else                               stop = -1;
            if (!md && stop < 0) rst = 1'b0;
            run(lim, md, stop, rst, intf);
        end

        repeat (3) @(posedge clock);
        #1;
        chk("final_cnt_queue", qexp.size(), 0);
        chk("final_event_queue", evq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/updown_sweep_ctrl.md
# updown_sweep_ctrl

Sequencing controller for the 4-bit up/down counter: it drives the counter's `Reset` and `Down` inputs and watches its `q` output, so the counter sweeps 0 → limit → 0. A sweep runs either once or repeatedly until aborted. The controller also reports busy/done status and a count of completed sweeps. It sits between the control/register logic and the counter instance, and is the only driver of the counter's control pins.

## Interface
- No parameters; all widths are fixed. Counter width is 4, sweep count width is 8.
- `clock`  in  1  system clock, shared with the counter.
- `Reset`  in  1  reset, synchronous, active-high; clock `clock`.
- `start`  in  1  begins a run. Sampled only in IDLE.
- `abort`  in  1  terminates a run. Has priority over every other input except `Reset`.
- `mode`  in  1  0 = single sweep, 1 = continuous. Captured at start.
- `limit`  in  4  peak value of the sweep. Captured at start into `lim_r`.
- `cnt_q`  in  4  counter value fed back from the counter.
- `cnt_reset`  out  1  drives the counter's `Reset`. Combinational.
- `cnt_down`  out  1  drives the counter's `Down`. Combinational.
- `busy`  out  1  high when state ≠ IDLE.
- `done`  out  1  registered one-cycle pulse: a single-mode sweep has completed.
- `err`  out  1  registered one-cycle pulse: start was rejected because `limit` = 0.
- `peak`  out  1  registered one-cycle pulse: the counter turned around at `lim_r`.
- `sweeps`  out  8  completed sweeps since the last accepted start. Saturates at 255.

## Operation
- The counter advances every clock edge and has no enable. The controller holds it at 0 by asserting `cnt_reset`.
- State register has three states: IDLE, UP, DOWN.
- IDLE
  - Outputs: `cnt_reset`=1, `cnt_down`=0.
  - `start` with `limit` ≠ 0: capture `limit` and `mode`, clear `sweeps`, go to UP.
  - `start` with `limit` = 0: stay in IDLE, pulse `err`.
- UP
  - Outputs: `cnt_reset`=0, `cnt_down` = (`cnt_q` ≥ `lim_r`).
  - When `cnt_q` ≥ `lim_r`: go to DOWN, pulse `peak`.
  - The ≥ comparison is a safety turnaround; the counter never exceeds `lim_r`.
- DOWN
  - When `cnt_q` ≠ 0: `cnt_down`=1, `cnt_reset`=0.
  - When `cnt_q` = 0, the sweep ends and `sweeps` increments, saturating at 255.
    - mode 0: `cnt_reset`=1, so the counter never wraps to 0xF. Go to IDLE and pulse `done`.
    - mode 1: `cnt_down`=0, `cnt_reset`=0, so the counter goes to 1. Go to UP.
- `abort` in UP or DOWN, same cycle:
  - `cnt_reset`=1 combinationally, and the state goes to IDLE.
  - No `done`, no `sweeps` increment.
  - `sweeps` keeps its value until the next accepted start.
- `abort` in IDLE has no effect.
- `start` while busy is ignored. Changes to `limit` or `mode` while busy are ignored.
- `cnt_reset` is also asserted whenever `Reset` is high, so the counter clears in the same edge.
- Reset values:
  - state IDLE, `busy`=0, `done`=0, `err`=0, `peak`=0, `sweeps`=0, `lim_r`=0, mode register = 0.
  - `cnt_reset`=1, `cnt_down`=0.

## Timing
- Start acceptance: `start` is sampled at edge E0. `busy`=1 from the cycle after E0, and `cnt_q`=0 in that first UP cycle.
- Sweep sequence for limit L, one value per cycle: 0, 1, …, L, L−1, …, 0.
  - Single sweep: `busy` high for 2L+1 cycles.
  - `done` is high in the first cycle after `busy` falls, and `cnt_q`=0 in that cycle.
- Continuous mode: period is 2L cycles, sequence 0, 1, …, L, …, 1, 0, 1, …
- `peak`: high in the cycle after the cycle where `cnt_q` = L.
- `sweeps`: the updated value is visible in the cycle after the sweep-end cycle.
- Abort: with `abort` high in cycle C, `cnt_q`=0 and `busy`=0 from cycle C+1.
- Reset mid-run: same observable effect as abort, plus `sweeps` is cleared.
- No combinational path from `start` to any output. The only combinational paths are `cnt_q`/`abort`/`Reset` → `cnt_reset`/`cnt_down`.

## Test plan
- Reset and idle: hold `Reset` 2 cycles, then idle 5 cycles → `cnt_reset`=1, `cnt_q`=0 throughout, `busy`=0, `sweeps`=0, no pulses.
- Single sweep, `limit`=3, `mode`=0:
  - `cnt_q` = 0,1,2,3,2,1,0 and `busy` high for 7 cycles.
  - `peak` pulses once; `done` pulses once with `cnt_q`=0, which then holds 0.
  - `sweeps`=1.
- Continuous, `limit`=2, `mode`=1, `abort` on the 10th busy cycle:
  - `cnt_q` = 0,1,2,1,0,1,2,1,0,1.
  - `sweeps`=2; after abort, `cnt_q`=0 next cycle, `busy`=0, no `done`.
- Boundaries, `limit`=0 then `limit`=15:
  - `limit`=0 → `err` pulse, `busy` stays 0.
  - `limit`=15 → `cnt_q` climbs to 0xF, descends to 0, never wraps; `busy` high for 31 cycles.
- Interference during a `limit`=4 run:
  - Pulse `start` and change `limit` to 9 mid-run → ignored; the sweep still peaks at 4.
  - Assert `Reset` mid-run → `busy`=0 and `cnt_q`=0 next cycle, `sweeps`=0.
- Saturation: continuous, `limit`=1, run 300 sweeps → `sweeps` sticks at 255.
